// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: synchronized pin sampling, RX word assembly, TX shift-out.
// Optional feature macro: SPI_RESP_LOOPBACK_EN (echo last received word on MISO).
module spi_slave_responder #(
    parameter int unsigned         WORD_W       = 65,
    parameter logic [WORD_W-1:0]   IDLE_PATTERN = {WORD_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SCLK,
    input  logic              SCS,
    input  logic              MOSI,
    output logic              MISO,
    input  logic              pndgn,
    input  logic [WORD_W-1:0] D_pop,
    output logic              pop,
    output logic [WORD_W-1:0] D_push,
    output logic              push,
    output logic              frame_abort,
    output logic              underrun
);

    localparam int unsigned     CW   = $clog2(WORD_W);
    localparam logic [CW-1:0]   LAST = CW'(WORD_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       bit_cnt_q;
    logic [WORD_W-1:0]   tx_sr_q;
    logic [WORD_W-2:0]   rx_sr_q;
    logic [2:0]          sclk_q;
    logic [2:0]          scs_q;
    logic [1:0]          mosi_q;

    logic                rise_e;
    logic                fall_e;
    logic                cs_fall_e;
    logic                cs_rise_e;
    logic                complete;
    logic                load;
    logic [WORD_W-1:0]   word;
    logic [WORD_W-1:0]   load_word;

    // Pin synchronizers; the third stage on SCLK/SCS feeds the edge detects.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_q <= 3'b000;
            scs_q  <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], SCLK};
            scs_q  <= {scs_q[1:0], SCS};
            mosi_q <= {mosi_q[0], MOSI};
        end
    end

    assign rise_e    = sclk_q[1] & ~sclk_q[2];
    assign fall_e    = ~sclk_q[1] & sclk_q[2];
    assign cs_fall_e = ~scs_q[1] & scs_q[2];
    assign cs_rise_e = scs_q[1] & ~scs_q[2];

    assign word     = {rx_sr_q, mosi_q[1]};
    assign complete = (state_q == SHIFT) && rise_e && (bit_cnt_q == LAST);
    assign load     = ((state_q == IDLE) && cs_fall_e)
                    || (complete && !cs_rise_e);

    assign push   = complete;
    assign D_push = complete ? word : '0;
    assign MISO   = (state_q == SHIFT) ? tx_sr_q[WORD_W-1] : 1'b0;

    // A partial word is one whose sampled bit count is nonzero after this cycle.
    assign frame_abort = (state_q == SHIFT) && cs_rise_e
                       && (rise_e ? !complete : (bit_cnt_q != '0));

`ifdef SPI_RESP_LOOPBACK_EN
    logic [WORD_W-1:0] echo_q;
    logic              unused_fifo;

    assign unused_fifo = ^{pndgn, D_pop};
    assign pop         = 1'b0;
    assign underrun    = 1'b0;
    // A word completing this cycle is echoed immediately on the next word.
    assign load_word   = complete ? word : echo_q;

    // Echo register holds the most recently pushed word across frames.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            echo_q <= IDLE_PATTERN;
        end else if (complete) begin
            echo_q <= word;
        end
    end
`else
    assign pop       = load & pndgn;
    assign underrun  = load & ~pndgn;
    assign load_word = pndgn ? D_pop : IDLE_PATTERN;
`endif

    // Frame FSM: word loads, RX sampling on rise, TX shifting on fall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
        end else begin
            if (load) begin
                tx_sr_q <= load_word;
            end
            unique case (state_q)
                IDLE: begin
                    bit_cnt_q <= '0;
                    if (cs_fall_e) begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rise_e) begin
                        rx_sr_q   <= word[WORD_W-2:0];
                        bit_cnt_q <= complete ? '0 : bit_cnt_q + CW'(1);
                    end else if (fall_e && (bit_cnt_q != '0)) begin
                        tx_sr_q <= tx_sr_q << 1;
                    end
                    if (cs_rise_e) begin
                        state_q   <= IDLE;
                        bit_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder at WORD_W=8 with a bench-side
// SPI master (SCLK period 8 clk) and a first-word fall-through TX FIFO model.
module tb_spi_slave_responder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         SCLK;
    logic         SCS;
    logic         MOSI;
    logic         MISO;
    logic         pndgn = 1'b0;
    logic [W-1:0] D_pop = '0;
    logic         pop;
    logic [W-1:0] D_push;
    logic         push;
    logic         frame_abort;
    logic         underrun;

    int vec_cnt = 0;
    int err_cnt = 0;
    int pop_cnt = 0;
    int und_cnt = 0;
    int abt_cnt = 0;
    bit pop_armed = 1'b0;

    logic [W-1:0] push_d[$];
    logic [W-1:0] txq[$];
    logic [W-1:0] mtx[3];
    logic [W-1:0] mrx[3];

    spi_slave_responder #(
        .WORD_W      (W),
        .IDLE_PATTERN({W{1'b1}})
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .SCLK       (SCLK),
        .SCS        (SCS),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .pndgn      (pndgn),
        .D_pop      (D_pop),
        .pop        (pop),
        .D_push     (D_push),
        .push       (push),
        .frame_abort(frame_abort),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    // Strobe monitor and FIFO model; the head is dropped one cycle after pop
    // so the DUT captures D_pop on the edge that ends the pop cycle.
    always @(negedge clk) begin
        if (pop_armed) begin
            if (txq.size() != 0) txq.delete(0);
            pop_armed = 1'b0;
        end
        if (pop) begin
            pop_cnt++;
            pop_armed = 1'b1;
        end
        if (push) push_d.push_back(D_push);
        if (underrun) und_cnt++;
        if (frame_abort) abt_cnt++;
        pndgn = (txq.size() != 0);
        D_pop = pndgn ? txq[0] : '0;
    end

    task automatic send_bits(input logic [W-1:0] w, input int nb,
                             output logic [W-1:0] r);
        r = '0;
        for (int i = W - 1; i >= W - nb; i--) begin
            MOSI = w[i];
            repeat (4) @(negedge clk);
            r[i] = MISO;
            SCLK = 1'b1;
            repeat (4) @(negedge clk);
            SCLK = 1'b0;
        end
    endtask

    task automatic frame(input int nw, input int lastbits);
        logic [W-1:0] r;
        SCS = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < nw; k++) begin
            send_bits(mtx[k], (k == nw - 1) ? lastbits : W, r);
            mrx[k] = r;
        end
        repeat (4) @(negedge clk);
        SCS = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        SCLK  = 1'b0;
        SCS   = 1'b1;
        MOSI  = 1'b0;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (MISO !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_miso: got %b want 0", MISO);
        end
        vec_cnt++;
        if (pop !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_pop: got %b want 0", pop);
        end
        vec_cnt++;
        if (push !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_push: got %b want 0", push);
        end
        vec_cnt++;
        if (frame_abort !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_abort: got %b want 0", frame_abort);
        end
        vec_cnt++;
        if (underrun !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_underrun: got %b want 0", underrun);
        end
        vec_cnt++;
        if (D_push !== 8'h00) begin
            err_cnt++;
            $display("FAIL rst_dpush: got %h want 00", D_push);
        end
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

`ifndef SPI_RESP_LOOPBACK_EN
    task automatic test_single;
        int pb = push_d.size();
        int p0 = pop_cnt;
        int u0 = und_cnt;
        logic [W-1:0] got;
        txq.push_back(8'hA5);
        repeat (2) @(negedge clk);
        mtx[0] = 8'h3C;
        frame(1, W);
        vec_cnt++;
        if (mrx[0] !== 8'hA5) begin
            err_cnt++;
            $display("FAIL single_miso: got %h want a5", mrx[0]);
        end
        vec_cnt++;
        if (push_d.size() - pb !== 1) begin
            err_cnt++;
            $display("FAIL single_npush: got %0d want 1", push_d.size() - pb);
        end
        got = (push_d.size() > pb) ? push_d[pb] : 'x;
        vec_cnt++;
        if (got !== 8'h3C) begin
            err_cnt++;
            $display("FAIL single_dpush: got %h want 3c", got);
        end
        vec_cnt++;
        if (pop_cnt - p0 !== 1) begin
            err_cnt++;
            $display("FAIL single_pop: got %0d want 1", pop_cnt - p0);
        end
        // Word completion with SCS still low reloads from an empty FIFO.
        vec_cnt++;
        if (und_cnt - u0 !== 1) begin
            err_cnt++;
            $display("FAIL single_underrun: got %0d want 1", und_cnt - u0);
        end
    endtask

    task automatic test_back_to_back;
        int pb = push_d.size();
        int p0 = pop_cnt;
        logic [W-1:0] exp_rx[3];
        logic [W-1:0] exp_tx[3];
        logic [W-1:0] got;
        exp_rx = '{8'h11, 8'h22, 8'h33};
        exp_tx = '{8'h01, 8'h02, 8'h03};
        txq.push_back(8'h11);
        txq.push_back(8'h22);
        txq.push_back(8'h33);
        repeat (2) @(negedge clk);
        mtx[0] = 8'h01;
        mtx[1] = 8'h02;
        mtx[2] = 8'h03;
        frame(3, W);
        for (int k = 0; k < 3; k++) begin
            vec_cnt++;
            if (mrx[k] !== exp_rx[k]) begin
                err_cnt++;
                $display("FAIL b2b_miso%0d: got %h want %h", k, mrx[k], exp_rx[k]);
            end
            got = (push_d.size() > pb + k) ? push_d[pb + k] : 'x;
            vec_cnt++;
            if (got !== exp_tx[k]) begin
                err_cnt++;
                $display("FAIL b2b_dpush%0d: got %h want %h", k, got, exp_tx[k]);
            end
        end
        vec_cnt++;
        if (push_d.size() - pb !== 3) begin
            err_cnt++;
            $display("FAIL b2b_npush: got %0d want 3", push_d.size() - pb);
        end
        vec_cnt++;
        if (pop_cnt - p0 !== 3) begin
            err_cnt++;
            $display("FAIL b2b_pop: got %0d want 3", pop_cnt - p0);
        end
    endtask

    task automatic test_underrun;
        int pb = push_d.size();
        int p0 = pop_cnt;
        int u0 = und_cnt;
        logic [W-1:0] got;
        mtx[0] = 8'h96;
        frame(1, W);
        vec_cnt++;
        if (mrx[0] !== 8'hFF) begin
            err_cnt++;
            $display("FAIL und_miso: got %h want ff", mrx[0]);
        end
        vec_cnt++;
        if (pop_cnt - p0 !== 0) begin
            err_cnt++;
            $display("FAIL und_pop: got %0d want 0", pop_cnt - p0);
        end
        // One at SCS fall, one at the word-complete reload.
        vec_cnt++;
        if (und_cnt - u0 !== 2) begin
            err_cnt++;
            $display("FAIL und_count: got %0d want 2", und_cnt - u0);
        end
        got = (push_d.size() > pb) ? push_d[pb] : 'x;
        vec_cnt++;
        if (got !== 8'h96) begin
            err_cnt++;
            $display("FAIL und_dpush: got %h want 96", got);
        end
    endtask

    task automatic test_abort;
        int pb = push_d.size();
        int a0 = abt_cnt;
        logic [W-1:0] got;
        mtx[0] = 8'hE7;
        frame(1, 5);
        vec_cnt++;
        if (abt_cnt - a0 !== 1) begin
            err_cnt++;
            $display("FAIL abort_pulse: got %0d want 1", abt_cnt - a0);
        end
        vec_cnt++;
        if (push_d.size() - pb !== 0) begin
            err_cnt++;
            $display("FAIL abort_nopush: got %0d want 0", push_d.size() - pb);
        end
        mtx[0] = 8'h5A;
        frame(1, W);
        got = (push_d.size() > pb) ? push_d[pb] : 'x;
        vec_cnt++;
        if (got !== 8'h5A) begin
            err_cnt++;
            $display("FAIL abort_next: got %h want 5a", got);
        end
        vec_cnt++;
        if (abt_cnt - a0 !== 1) begin
            err_cnt++;
            $display("FAIL abort_clean: got %0d want 1", abt_cnt - a0);
        end
    endtask

    task automatic test_reset_midframe;
        int pb;
        int a0;
        logic [W-1:0] r;
        logic [W-1:0] got;
        SCS = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(8'hC3, 3, r);
        reset = 1'b0;
        SCS   = 1'b1;
        SCLK  = 1'b0;
        MOSI  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vec_cnt++;
            if ({MISO, pop, push, frame_abort, underrun, D_push} !== '0) begin
                err_cnt++;
                $display("FAIL midrst_outs%0d: got %b want 0", c,
                         {MISO, pop, push, frame_abort, underrun, D_push});
            end
        end
        reset = 1'b1;
        repeat (4) @(negedge clk);
        pb = push_d.size();
        a0 = abt_cnt;
        mtx[0] = 8'hC3;
        frame(1, W);
        got = (push_d.size() > pb) ? push_d[pb] : 'x;
        vec_cnt++;
        if (got !== 8'hC3) begin
            err_cnt++;
            $display("FAIL midrst_rx: got %h want c3", got);
        end
        vec_cnt++;
        if (push_d.size() - pb !== 1) begin
            err_cnt++;
            $display("FAIL midrst_npush: got %0d want 1", push_d.size() - pb);
        end
        vec_cnt++;
        if (abt_cnt - a0 !== 0) begin
            err_cnt++;
            $display("FAIL midrst_abort: got %0d want 0", abt_cnt - a0);
        end
    endtask
`else
    task automatic test_loopback;
        int pb = push_d.size();
        int p0 = pop_cnt;
        int u0 = und_cnt;
        logic [W-1:0] got;
        mtx[0] = 8'h12;
        mtx[1] = 8'h34;
        frame(2, W);
        vec_cnt++;
        if (mrx[0] !== 8'hFF) begin
            err_cnt++;
            $display("FAIL lb_miso0: got %h want ff", mrx[0]);
        end
        vec_cnt++;
        if (mrx[1] !== 8'h12) begin
            err_cnt++;
            $display("FAIL lb_miso1: got %h want 12", mrx[1]);
        end
        got = (push_d.size() > pb + 1) ? push_d[pb + 1] : 'x;
        vec_cnt++;
        if (got !== 8'h34) begin
            err_cnt++;
            $display("FAIL lb_dpush1: got %h want 34", got);
        end
        vec_cnt++;
        if (pop_cnt - p0 !== 0) begin
            err_cnt++;
            $display("FAIL lb_pop: got %0d want 0", pop_cnt - p0);
        end
        vec_cnt++;
        if (und_cnt - u0 !== 0) begin
            err_cnt++;
            $display("FAIL lb_underrun: got %0d want 0", und_cnt - u0);
        end
        // Echo persists: next frame opens with the last word of this one.
        mtx[0] = 8'h77;
        frame(1, W);
        vec_cnt++;
        if (mrx[0] !== 8'h34) begin
            err_cnt++;
            $display("FAIL lb_persist: got %h want 34", mrx[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifndef SPI_RESP_LOOPBACK_EN
        test_single();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_reset_midframe();
`else
        test_loopback();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
